// File: rtl/saida_display_if.sv
// Output-path bundle between the processor and saida_display: command word,
// mode and the registered display/handshake outputs.
interface saida_display_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8
);
    logic [DATA_W-1:0]       dado;
    logic                    controle;
    logic                    modo;
    logic [7*NUM_DIGITS-1:0] seg;
    logic                    neg;
    logic                    ocupado;
    logic                    pronto;

    modport master (
        output dado, controle, modo,
        input  seg, neg, ocupado, pronto
    );

    modport slave (
        input  dado, controle, modo,
        output seg, neg, ocupado, pronto
    );
endinterface

// File: rtl/saida_display.sv
// Signed-word seven-segment driver: single-cycle hex path, sequential double-dabble decimal path.
// Optional macro SAIDA_DISPLAY_BLANK_EN blanks leading zeros in decimal mode.
module saida_display #(
    parameter int DATA_W         = 32,
    parameter int NUM_DIGITS     = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    saida_display_if.slave   bus
);
    localparam int BCD_D     = (DATA_W + 2) / 3;
    localparam int EXT_D     = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
    localparam int HEX_EXT_W = (4 * NUM_DIGITS > DATA_W) ? 4 * NUM_DIGITS : DATA_W;
    localparam int SEG_W     = 7 * NUM_DIGITS;
    localparam int CNT_W     = $clog2(DATA_W + 1);

    localparam logic [6:0]       GLYPH_DASH   = 7'b0111111;
    localparam logic [SEG_W-1:0] ZERO_PATTERN = {NUM_DIGITS{7'b1000000}};

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t                 state;
    logic [SEG_W-1:0]       seg_r;
    logic                   neg_r;
    logic                   ocupado_r;
    logic                   pronto_r;
    logic [4*BCD_D-1:0]     bcd;
    logic [DATA_W-1:0]      mag_sh;
    logic                   sign_r;
    logic [CNT_W-1:0]       cnt;

    logic signed [DATA_W-1:0] dado_s;
    logic                     sign_in;
    logic [DATA_W-1:0]        mag_in;

    // Negating the most negative value wraps to 2^(DATA_W-1), which is the
    // correct unsigned magnitude.
    assign dado_s  = $signed(bus.dado);
    assign sign_in = dado_s[DATA_W-1];
    assign mag_in  = sign_in ? DATA_W'(-dado_s) : DATA_W'(dado_s);

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [SEG_W-1:0] hex_pattern(input logic [DATA_W-1:0] m);
        logic [HEX_EXT_W-1:0] ext;
        logic [SEG_W-1:0]     p;
        ext = HEX_EXT_W'(m);
        p   = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            p[7*k +: 7] = glyph(ext[4*k +: 4]);
        return p;
    endfunction

    function automatic logic [4*BCD_D-1:0] dabble(input logic [4*BCD_D-1:0] b,
                                                  input logic             bit_in);
        logic [4*BCD_D-1:0] a;
        a = b;
        for (int k = 0; k < BCD_D; k++)
            if (a[4*k +: 4] >= 4'd5)
                a[4*k +: 4] = a[4*k +: 4] + 4'd3;
        return (a << 1) | {{(4*BCD_D-1){1'b0}}, bit_in};
    endfunction

    function automatic logic [SEG_W-1:0] dec_pattern(input logic [4*BCD_D-1:0] b);
        logic [4*EXT_D-1:0] ext;
        logic [SEG_W-1:0]   p;
        logic               ovf;
`ifdef SAIDA_DISPLAY_BLANK_EN
        logic               seen;
`endif
        ext                = '0;
        ext[4*BCD_D-1:0]   = b;
        ovf                = 1'b0;
        p                  = '0;
        for (int k = NUM_DIGITS; k < EXT_D; k++)
            if (ext[4*k +: 4] != 4'd0)
                ovf = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++)
            p[7*k +: 7] = glyph(ext[4*k +: 4]);
`ifdef SAIDA_DISPLAY_BLANK_EN
        // Walk down from the top digit; everything before the first nonzero
        // digit is blank, except digit 0 so a zero result still reads "0".
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (ext[4*k +: 4] != 4'd0)
                seen = 1'b1;
            if (!seen)
                p[7*k +: 7] = 7'b1111111;
        end
`endif
        if (ovf)
            p = {NUM_DIGITS{GLYPH_DASH}};
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seg_r     <= ZERO_PATTERN;
            neg_r     <= 1'b0;
            ocupado_r <= 1'b0;
            pronto_r  <= 1'b0;
            bcd       <= '0;
            mag_sh    <= '0;
            sign_r    <= 1'b0;
            cnt       <= '0;
        end else begin
            pronto_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.controle) begin
                        if (!bus.modo) begin
                            seg_r    <= hex_pattern(mag_in);
                            neg_r    <= sign_in;
                            pronto_r <= 1'b1;
                        end else begin
                            mag_sh    <= mag_in;
                            sign_r    <= sign_in;
                            bcd       <= '0;
                            cnt       <= '0;
                            ocupado_r <= 1'b1;
                            state     <= CONV;
                        end
                    end
                end
                // One double-dabble step per cycle, MSB of the magnitude first.
                CONV: begin
                    bcd    <= dabble(bcd, mag_sh[DATA_W-1]);
                    mag_sh <= mag_sh << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= LOAD;
                end
                LOAD: begin
                    seg_r     <= dec_pattern(bcd);
                    neg_r     <= sign_r;
                    pronto_r  <= 1'b1;
                    ocupado_r <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.seg     = SEG_ACTIVE_LOW ? seg_r : ~seg_r;
    assign bus.neg     = neg_r;
    assign bus.ocupado = ocupado_r;
    assign bus.pronto  = pronto_r;
endmodule
